// File: rtl/icon_pkg.sv
// Shared types and helpers for the NwNr heap interconnect switch nodes.
package icon_pkg;

  localparam int ICON_RET_DEPTH_DEF = 8;

  typedef logic scb_t;

  // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
  function automatic int icon_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/icon_scb_fifo.sv
// In-order FIFO of 1-bit switch-control bits recorded by the forward node.
// A pop frees its slot in the same cycle, so push+pop while full is accepted.
module icon_scb_fifo
  import icon_pkg::*;
#(
  parameter int DEPTH = ICON_RET_DEPTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  scb_t                   i_scb,
  input  logic                   i_pop,
  output scb_t                   o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = icon_ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  scb_t          mem_q [DEPTH];

  logic pop_ok;
  logic push_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = mem_q[head_q];

  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop_ok)  head_q <= head_q + PW'(1);
      if (push_ok) tail_q <= tail_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define
  // which slots are valid, and an unreset array maps to plain RAM/flops.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[tail_q] <= i_scb;
  end

endmodule

// File: rtl/icon_ret_node.sv
// Return-path 2x2 switch node: replays the forward node's swap on responses.
// Optional sticky error flags and assertions are enabled by ICON_RET_ERR_EN.
module icon_ret_node
  import icon_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int DEPTH    = ICON_RET_DEPTH_DEF,
  parameter int PIPELINE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fwd_valid,
  input  scb_t                   i_fwd_scb,
  input  logic                   i_valid_0,
  input  logic                   i_valid_1,
  input  logic [DATA_W-1:0]      i_data_0,
  input  logic [DATA_W-1:0]      i_data_1,
  output logic                   o_valid_0,
  output logic                   o_valid_1,
  output logic [DATA_W-1:0]      o_data_0,
  output logic [DATA_W-1:0]      o_data_1,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_err_ovf,
  output logic                   o_err_udf
);

  logic pop;
  scb_t head;
  logic swap;

  logic              sw_valid_0;
  logic              sw_valid_1;
  logic [DATA_W-1:0] sw_data_0;
  logic [DATA_W-1:0] sw_data_1;

  assign pop = i_valid_0 | i_valid_1;

  icon_scb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_fwd_valid),
    .i_scb   (i_fwd_scb),
    .i_pop   (pop),
    .o_head  (head),
    .o_full  (o_full),
    .o_empty (o_empty),
    .o_count (o_count)
  );

  // An empty FIFO has no recorded route, so the response passes straight.
  assign swap = pop & ~o_empty & head;

  always_comb begin
    sw_valid_0 = swap ? i_valid_1 : i_valid_0;
    sw_valid_1 = swap ? i_valid_0 : i_valid_1;
    sw_data_0  = swap ? i_data_1  : i_data_0;
    sw_data_1  = swap ? i_data_0  : i_data_1;
  end

  generate
    if (PIPELINE != 0) begin : g_pipe
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          o_valid_0 <= 1'b0;
          o_valid_1 <= 1'b0;
          o_data_0  <= '0;
          o_data_1  <= '0;
        end else begin
          o_valid_0 <= sw_valid_0;
          o_valid_1 <= sw_valid_1;
          o_data_0  <= sw_data_0;
          o_data_1  <= sw_data_1;
        end
      end
    end else begin : g_comb
      assign o_valid_0 = sw_valid_0;
      assign o_valid_1 = sw_valid_1;
      assign o_data_0  = sw_data_0;
      assign o_data_1  = sw_data_1;
    end
  endgenerate

`ifdef ICON_RET_ERR_EN
  logic ovf_evt;
  logic udf_evt;
  logic err_ovf_q;
  logic err_udf_q;

  // Overflow only when full and no pop is freeing a slot this cycle.
  assign ovf_evt = i_fwd_valid & o_full & ~(pop & ~o_empty);
  assign udf_evt = pop & o_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (ovf_evt) err_ovf_q <= 1'b1;
      if (udf_evt) err_udf_q <= 1'b1;
    end
  end

  assign o_err_ovf = err_ovf_q;
  assign o_err_udf = err_udf_q;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      assert (!ovf_evt) else $warning("icon_ret_node: scb overflow, entry dropped");
      assert (!udf_evt) else $warning("icon_ret_node: return with no outstanding scb");
    end
  end
`endif
`else
  assign o_err_ovf = 1'b0;
  assign o_err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_icon_ret_node.sv
// Self-checking bench for icon_ret_node (DATA_W=8, DEPTH=8, PIPELINE=1) against a queue model.
module tb_icon_ret_node;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              i_clk;
  logic              i_rst;
  logic              i_fwd_valid;
  logic              i_fwd_scb;
  logic              i_valid_0;
  logic              i_valid_1;
  logic [DATA_W-1:0] i_data_0;
  logic [DATA_W-1:0] i_data_1;
  logic              o_valid_0;
  logic              o_valid_1;
  logic [DATA_W-1:0] o_data_0;
  logic [DATA_W-1:0] o_data_1;
  logic              o_full;
  logic              o_empty;
  logic [3:0]        o_count;
  logic              o_err_ovf;
  logic              o_err_udf;

  icon_ret_node #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .PIPELINE (1)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_fwd_valid (i_fwd_valid),
    .i_fwd_scb   (i_fwd_scb),
    .i_valid_0   (i_valid_0),
    .i_valid_1   (i_valid_1),
    .i_data_0    (i_data_0),
    .i_data_1    (i_data_1),
    .o_valid_0   (o_valid_0),
    .o_valid_1   (o_valid_1),
    .o_data_0    (o_data_0),
    .o_data_1    (o_data_1),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_err_ovf   (o_err_ovf),
    .o_err_udf   (o_err_udf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding scb values in request order plus sticky flags.
  bit         model_q[$];
  bit         m_ovf;
  bit         m_udf;
  logic [17:0] exp_out;
  logic [7:0]  exp_stat;

  wire [17:0] dut_out  = {o_valid_0, o_valid_1, o_data_0, o_data_1};
  wire [7:0]  dut_stat = {o_count, o_full, o_empty, o_err_ovf, o_err_udf};

  function automatic bit err_vis(input bit f);
`ifdef ICON_RET_ERR_EN
    return f;
`else
    return 1'b0 & f;
`endif
  endfunction

  function automatic logic [7:0] model_stat();
    int n = model_q.size();
    return {4'(n), (n == DEPTH), (n == 0), err_vis(m_ovf), err_vis(m_udf)};
  endfunction

  // Drives one cycle, advances the model, and returns #1 after the edge.
  task automatic step(input bit push, input bit scb, input bit v0, input bit v1,
                      input logic [7:0] d0, input logic [7:0] d1);
    bit sw = 1'b0;
    i_fwd_valid = push;
    i_fwd_scb   = scb;
    i_valid_0   = v0;
    i_valid_1   = v1;
    i_data_0    = d0;
    i_data_1    = d1;
    if (v0 | v1) begin
      if (model_q.size() > 0) sw = model_q.pop_front();
      else m_udf = 1'b1;
    end
    if (push) begin
      if (model_q.size() < DEPTH) model_q.push_back(scb);
      else m_ovf = 1'b1;
    end
    exp_out  = sw ? {v1, v0, d1, d0} : {v0, v1, d0, d1};
    @(posedge i_clk);
    #1;
    exp_stat    = model_stat();
    i_fwd_valid = 1'b0;
    i_valid_0   = 1'b0;
    i_valid_1   = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_fwd_valid = 1'b0; i_fwd_scb = 1'b0;
    i_valid_0 = 1'b0; i_valid_1 = 1'b0;
    i_data_0 = '0; i_data_1 = '0;
    model_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    #3;
    n_checks++;
    if (dut_out !== 18'h0) begin
      n_fail++; $display("FAIL reset_out: got %h want %h", dut_out, 18'h0);
    end
    n_checks++;
    if (dut_stat !== 8'b0000_0100) begin
      n_fail++; $display("FAIL reset_stat: got %b want %b", dut_stat, 8'b0000_0100);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] a = 8'hA5;
    logic [7:0] b = 8'h3C;
    logic [17:0] want [3];
    want[0] = {2'b11, b, a};
    want[1] = {2'b11, a, b};
    want[2] = {2'b11, b, a};
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (o_count !== 4'd3) begin
      n_fail++; $display("FAIL basic_count3: got %0d want 3", o_count);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, a, b);
      n_checks++;
      if (dut_out !== want[i]) begin
        n_fail++; $display("FAIL basic_out%0d: got %h want %h", i, dut_out, want[i]);
      end
    end
    n_checks++;
    if (dut_stat !== exp_stat || o_count !== 4'd0) begin
      n_fail++; $display("FAIL basic_drain: got %b want %b", dut_stat, exp_stat);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1, bit'($urandom_range(0, 1)), 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      int ln = $urandom_range(1, 3);
      step(1, bit'($urandom_range(0, 1)), ln[0], ln[1], 8'($urandom), 8'($urandom));
      n_checks++;
      if (dut_out !== exp_out) begin
        n_fail++; $display("FAIL b2b_out%0d: got %h want %h", i, dut_out, exp_out);
      end
      n_checks++;
      if (o_count !== 4'd3 || dut_stat !== exp_stat) begin
        n_fail++; $display("FAIL b2b_stat%0d: got %b want %b", i, dut_stat, exp_stat);
      end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'($urandom), 8'($urandom));
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1, bit'($urandom_range(0, 1)), 0, 0, 0, 0);
    n_checks++;
    if (o_full !== 1'b1 || o_count !== 4'd8) begin
      n_fail++; $display("FAIL ovf_fill: got full=%b count=%0d want full=1 count=8", o_full, o_count);
    end
    step(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (dut_stat !== exp_stat) begin
      n_fail++; $display("FAIL ovf_push: got %b want %b", dut_stat, exp_stat);
    end
  endtask

  task automatic test_full_push_pop();
    bit new_scb = bit'($urandom_range(0, 1));
    logic [7:0] a = 8'h11;
    logic [7:0] b = 8'hEE;
    logic [7:0] ovf_before = exp_stat;
    step(1, new_scb, 1, 1, a, b);
    n_checks++;
    if (dut_stat !== exp_stat || dut_stat !== ovf_before) begin
      n_fail++; $display("FAIL full_pp_stat: got %b want %b", dut_stat, exp_stat);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 1, a, b);
      n_checks++;
      if (dut_out !== exp_out) begin
        n_fail++; $display("FAIL full_pp_out%0d: got %h want %h", i, dut_out, exp_out);
      end
    end
    n_checks++;
    if (o_data_0 !== (new_scb ? b : a)) begin
      n_fail++; $display("FAIL full_pp_new: got %h want %h", o_data_0, new_scb ? b : a);
    end
  endtask

  task automatic test_underflow();
    step(0, 0, 1, 1, 8'd5, 8'd9);
    n_checks++;
    if (dut_out !== {2'b11, 8'd5, 8'd9}) begin
      n_fail++; $display("FAIL udf_out: got %h want %h", dut_out, {2'b11, 8'd5, 8'd9});
    end
    n_checks++;
    if (dut_stat !== exp_stat || o_err_udf !== err_vis(1'b1)) begin
      n_fail++; $display("FAIL udf_stat: got %b want %b", dut_stat, exp_stat);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 8'h77, 8'h88);
    #2;
    i_rst = 1'b0;
    model_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    n_checks++;
    if (dut_out !== 18'h0) begin
      n_fail++; $display("FAIL rst_mid_out: got %h want %h", dut_out, 18'h0);
    end
    n_checks++;
    if (dut_stat !== 8'b0000_0100) begin
      n_fail++; $display("FAIL rst_mid_stat: got %b want %b", dut_stat, 8'b0000_0100);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    step(0, 0, 1, 1, 8'h12, 8'h34);
    n_checks++;
    if (dut_out !== {2'b11, 8'h12, 8'h34} || dut_stat !== exp_stat) begin
      n_fail++; $display("FAIL rst_mid_udf: got %h/%b want %h/%b", dut_out, dut_stat,
                         {2'b11, 8'h12, 8'h34}, exp_stat);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit push = ($urandom_range(0, 99) < 55);
      bit v0   = ($urandom_range(0, 99) < 30);
      bit v1   = ($urandom_range(0, 99) < 30);
      step(push, bit'($urandom_range(0, 1)), v0, v1, 8'($urandom), 8'($urandom));
      n_checks++;
      if (dut_out !== exp_out || dut_stat !== exp_stat) begin
        n_fail++; $display("FAIL rand%0d: got %h/%b want %h/%b", i, dut_out, dut_stat,
                           exp_out, exp_stat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
